// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates dmem miss, load-use, branch flush and imem miss
// into per-stage enables, bubbles and flushes. Optional perf counters under STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use_stall,
    input  logic        branch_flush,
    input  logic        imem_req,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        mem_wb_bubble,
    output logic        imem_cancel,
    output logic        stall_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_dmem_cnt,
    output logic [31:0] perf_imem_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        IMEM_WAIT = 2'd2
    } state_t;

    // Winning cause for the current cycle; C_OFF covers the cycle between reset release and the first edge
    typedef enum logic [2:0] {
        C_OFF   = 3'd0,
        C_NONE  = 3'd1,
        C_DMEM  = 3'd2,
        C_LU    = 3'd3,
        C_FLUSH = 3'd4,
        C_IMEM  = 3'd5
    } cause_t;

    state_t             state_q;
    state_t             state_d;
    cause_t             cause;
    logic               active_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_q;
    logic               dmem_miss;
    logic               imem_miss;
    logic               in_wait;
    logic               enter_wait;

    assign dmem_miss     = dmem_req && !dmem_ready;
    assign imem_miss     = imem_req && !imem_ready;
    assign in_wait       = (state_q != RUN);
    assign enter_wait    = (state_d != RUN) && (state_d != state_q);
    assign cnt_inc       = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    assign stall_timeout = timeout_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    // Cause arbitration, next state and stage controls
    always_comb begin
        cause         = C_OFF;
        state_d       = state_q;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        imem_cancel   = 1'b0;

        if (!active_q) begin
            cause = C_OFF;
        end else if (state_q == DMEM_WAIT) begin
            // Stall inputs are ignored while memory holds the pipe
            cause = dmem_ready ? C_NONE : C_DMEM;
        end else if (dmem_miss) begin
            cause = C_DMEM;
        end else if (load_use_stall) begin
            cause = C_LU;
        end else if (branch_flush) begin
            cause = C_FLUSH;
        end else if (imem_miss) begin
            cause = C_IMEM;
        end else begin
            cause = C_NONE;
        end

        case (cause)
            C_NONE: begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                state_d   = RUN;
            end
            C_DMEM: begin
                mem_wb_bubble = 1'b1;
                state_d       = DMEM_WAIT;
            end
            C_LU: begin
                ex_mem_en     = 1'b1;
                mem_wb_en     = 1'b1;
                ex_mem_bubble = 1'b1;
                state_d       = RUN;
            end
            C_FLUSH: begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                // A redirect discards any fetch still in flight
                imem_cancel = imem_miss || (state_q == IMEM_WAIT);
                state_d     = RUN;
            end
            C_IMEM: begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
                state_d     = IMEM_WAIT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Wait watchdog: counts cycles spent in a wait state, sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (enter_wait) begin
                wait_cnt_q <= '0;
            end else if (in_wait) begin
                wait_cnt_q <= cnt_inc;
            end
            if (in_wait && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Per-cause winning-cycle counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_cnt    <= '0;
            perf_dmem_cnt  <= '0;
            perf_imem_cnt  <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (cause == C_LU)    perf_lu_cnt    <= perf_lu_cnt + 32'd1;
            if (cause == C_DMEM)  perf_dmem_cnt  <= perf_dmem_cnt + 32'd1;
            if (cause == C_IMEM)  perf_imem_cnt  <= perf_imem_cnt + 32'd1;
            if (cause == C_FLUSH) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, timeout/reset sequence, random vs. model.
module tb_pipeline_stall_ctrl;

    localparam int unsigned TO = 5;

    // Output vector order: pc,if_id,id_ex,ex_mem,mem_wb en | if_id_flush,id_ex_flush | ex_mem_bub,mem_wb_bub | cancel | timeout
    localparam logic [10:0] E_RUN = 11'b11111_00_00_0_0;
    localparam logic [10:0] E_FRZ = 11'b00000_00_01_0_0;
    localparam logic [10:0] E_LU  = 11'b00011_00_10_0_0;
    localparam logic [10:0] E_BF  = 11'b11111_11_00_0_0;
    localparam logic [10:0] E_BFC = 11'b11111_11_00_1_0;
    localparam logic [10:0] E_IM  = 11'b00111_01_00_0_0;

    // Input vector order: load_use, branch_flush, imem_req, imem_ready, dmem_req, dmem_ready
    typedef struct {
        logic [5:0]  in;
        logic [10:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic lu, bf, ireq, irdy, dreq, drdy;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble, imem_cancel, stall_timeout;
    logic [10:0] got;

    int n_vec;
    int n_err;

    // Reference model state: mode 0=running, 1=waiting on dmem, 2=waiting on imem
    int          m_mode;
    int          m_next;
    int          m_waited;
    bit          m_tout;
    bit          m_active;
    logic [10:0] m_exp;

    vec_t tbl [27];

    pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_stall (lu),
        .branch_flush   (bf),
        .imem_req       (ireq),
        .imem_ready     (irdy),
        .dmem_req       (dreq),
        .dmem_ready     (drdy),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .mem_wb_bubble  (mem_wb_bubble),
        .imem_cancel    (imem_cancel),
        .stall_timeout  (stall_timeout)
    );

    assign got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                  ex_mem_bubble, mem_wb_bubble, imem_cancel, stall_timeout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        m_mode   = 0;
        m_waited = 0;
        m_tout   = 1'b0;
        m_active = 1'b0;
    endfunction

    function automatic void model_eval(input logic [5:0] in);
        bit dmiss, imiss;
        dmiss = in[1] && !in[0];
        imiss = in[3] && !in[2];
        if (!m_active) begin
            m_exp = '0;  m_next = 0;
        end else if (m_mode == 1) begin
            if (in[0]) begin m_exp = E_RUN; m_next = 0; end
            else       begin m_exp = E_FRZ; m_next = 1; end
        end else if (dmiss) begin
            m_exp = E_FRZ; m_next = 1;
        end else if (in[5]) begin
            m_exp = E_LU;  m_next = 0;
        end else if (in[4]) begin
            m_exp = (imiss || m_mode == 2) ? E_BFC : E_BF;
            m_next = 0;
        end else if (imiss) begin
            m_exp = E_IM;  m_next = 2;
        end else begin
            m_exp = E_RUN; m_next = 0;
        end
        if (m_active) m_exp[0] = m_tout;
    endfunction

    function automatic void model_advance();
        if (m_active) begin
            if (m_mode != 0) begin
                m_waited++;
                if (m_waited == TO) m_tout = 1'b1;
            end
            if (m_next != 0 && m_next != m_mode) m_waited = 0;
            m_mode = m_next;
        end
        m_active = 1'b1;
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: drive after the edge, compare mid-cycle, advance model at the edge
    task automatic step(input logic [5:0] in, input logic [10:0] exp, input bit use_model,
                        input string name);
        {lu, bf, ireq, irdy, dreq, drdy} = in;
        @(negedge clk);
        model_eval(in);
        check(name, got, use_model ? m_exp : exp);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {lu, bf, ireq, irdy, dreq, drdy} = '0;
        #2;
        check("in_reset", got, 11'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(6'b000000, 11'b0, 1'b1, "post_release");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        {lu, bf, ireq, irdy, dreq, drdy} = '0;
        model_reset();

        tbl[0]  = '{6'b000000, E_RUN};   // idle after reset
        tbl[1]  = '{6'b100000, E_LU};    // load-use
        tbl[2]  = '{6'b000000, E_RUN};
        tbl[3]  = '{6'b000010, E_FRZ};   // dmem miss -> wait
        tbl[4]  = '{6'b000010, E_FRZ};
        tbl[5]  = '{6'b000010, E_FRZ};
        tbl[6]  = '{6'b000011, E_RUN};   // dmem ready: full advance
        tbl[7]  = '{6'b000000, E_RUN};
        tbl[8]  = '{6'b001000, E_IM};    // imem miss -> wait
        tbl[9]  = '{6'b001000, E_IM};
        tbl[10] = '{6'b011000, E_BFC};   // flush in imem wait cancels fetch
        tbl[11] = '{6'b001000, E_IM};
        tbl[12] = '{6'b001100, E_RUN};   // fetch arrives
        tbl[13] = '{6'b011000, E_BFC};   // flush with miss in RUN
        tbl[14] = '{6'b010000, E_BF};
        tbl[15] = '{6'b110010, E_FRZ};   // all causes: dmem wins
        tbl[16] = '{6'b110011, E_RUN};   // ready: stall inputs ignored
        tbl[17] = '{6'b110000, E_LU};    // load-use honoured next
        tbl[18] = '{6'b010000, E_BF};    // then the flush
        tbl[19] = '{6'b001010, E_FRZ};   // dmem beats imem miss
        tbl[20] = '{6'b001011, E_RUN};   // ready + imem miss: advance first
        tbl[21] = '{6'b001000, E_IM};
        tbl[22] = '{6'b001010, E_FRZ};   // dmem miss during imem wait
        tbl[23] = '{6'b001011, E_RUN};
        tbl[24] = '{6'b001100, E_RUN};
        tbl[25] = '{6'b101000, E_LU};    // load-use beats imem miss
        tbl[26] = '{6'b000000, E_RUN};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].in, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
        end

        // Watchdog: 10 cycles of dmem miss, flag visible once TO wait cycles have elapsed
        for (int c = 1; c <= 10; c++) begin
            step(6'b000010, E_FRZ | 11'((c >= 7) ? 1 : 0), 1'b0, $sformatf("tmo%0d", c));
        end
        step(6'b000011, E_RUN | 11'd1, 1'b0, "tmo_exit");
        step(6'b000000, E_RUN | 11'd1, 1'b0, "tmo_sticky");
        do_reset();
        step(6'b000000, E_RUN, 1'b0, "tmo_cleared");

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] in;
            in[5] = ($urandom_range(0, 5) == 0);
            in[4] = ($urandom_range(0, 7) == 0);
            in[3] = ($urandom_range(0, 1) == 0);
            in[2] = ($urandom_range(0, 2) == 0);
            in[1] = ($urandom_range(0, 2) == 0);
            in[0] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            step(in, 11'b0, 1'b1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes hazard and memory-latency stall requests and drives the per-stage enables, bubbles and flushes of the 5-stage pipeline (IF, ID, EX, MEM, WB).
- The load-use hazard detector produces `stall`; this block decides what each pipeline register does in response.
- It arbitrates four causes, in priority order: data-memory miss, load-use stall, branch flush, instruction-memory miss.
- It tracks multi-cycle memory waits with a small FSM and a watchdog counter.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles allowed in a wait state before `stall_timeout` sets.
- CNT_W, 10: width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_use_stall  in  1  load-use hazard request from the hazard unit (the unit's `stall` output).
- branch_flush  in  1  taken branch/jump resolved in EX; redirect PC.
- imem_req  in  1  IF stage has an outstanding fetch.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage holds a LW/SW.
- dmem_ready  in  1  data access completes this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP into ID/EX.
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- imem_cancel  out  1  one-cycle pulse that discards the outstanding fetch.
- stall_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = RUN, wait counter = 0, stall_timeout = 0.
  - All *_en = 0, all flush/bubble outputs = 0, imem_cancel = 0.
  - On the first clk edge after release, outputs follow the RUN rules.
- States: RUN, DMEM_WAIT, IMEM_WAIT. Outputs are combinational from state plus inputs; the state and counter are registered.
- RUN, with causes evaluated in priority order:
  1. dmem_req && !dmem_ready: all *_en = 0 and mem_wb_bubble = 1; next state DMEM_WAIT.
  2. load_use_stall: pc_en = if_id_en = id_ex_en = 0, ex_mem_en = 1, ex_mem_bubble = 1; remain in RUN.
  3. branch_flush: all *_en = 1, if_id_flush = 1, id_ex_flush = 1. If imem_req && !imem_ready, also pulse imem_cancel.
  4. imem_req && !imem_ready: pc_en = if_id_en = 0, id_ex_flush = 1, other enables = 1; next state IMEM_WAIT.
  5. None of the above: all *_en = 1, no flush or bubble.
- DMEM_WAIT:
  - All *_en = 0 and mem_wb_bubble = 1 every cycle.
  - When dmem_ready = 1: that cycle becomes a full advance (all *_en = 1, mem_wb_bubble = 0) and next state is RUN.
  - Stall inputs in this state are ignored; the producing stages are frozen, so requests re-present.
- IMEM_WAIT:
  - Same outputs as RUN cause 4.
  - Higher-priority causes are still evaluated each cycle.
  - dmem miss: next state DMEM_WAIT. The IF miss re-presents afterwards because imem_req stays high.
  - branch_flush: imem_cancel = 1, pc_en = 1, flushes as in RUN cause 3; next state RUN.
  - imem_ready: pc_en = if_id_en = 1; next state RUN.
- Wait counter:
  - Cleared on any transition into a wait state.
  - Increments each cycle spent in DMEM_WAIT or IMEM_WAIT and saturates at 2^CNT_W-1.
  - When the counter equals TIMEOUT_CYCLES, stall_timeout sets. It clears only on reset.
  - The FSM keeps waiting after a timeout; it does not force an exit.
- Simultaneous dmem_ready and imem miss in DMEM_WAIT: advance, then next state RUN; the IF miss is re-evaluated in RUN next cycle.
- Fixed invariants:
  - A stage register is never enabled while a downstream register is frozen.
  - A flush always coincides with the flushed register's enable being 1.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: adds output ports perf_lu_cnt, perf_dmem_cnt, perf_imem_cnt, perf_flush_cnt, each 32 bits.
  - Each counts the cycles in which its cause is the winning cause; perf_flush_cnt counts branch flushes.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Release reset with no requests -> the cycle after release has all *_en = 1 and no flush; stall_timeout = 0.
- load_use_stall = 1 for one cycle in RUN -> pc_en/if_id_en/id_ex_en = 0, ex_mem_bubble = 1, mem_wb_en = 1; the next cycle has all enables = 1.
- dmem_req = 1 with dmem_ready low for 3 cycles, then high -> 3 cycles of all *_en = 0 with mem_wb_bubble = 1, then one full advance; state returns to RUN.
- In IMEM_WAIT, branch_flush = 1 -> imem_cancel = 1, pc_en = 1, if_id_flush = id_ex_flush = 1; next state RUN.
- load_use_stall, branch_flush and a dmem miss all asserted together -> the dmem freeze wins (all *_en = 0); load-use and flush are honoured after dmem_ready.
- TIMEOUT_CYCLES = 5 with dmem_ready held low for 10 cycles -> stall_timeout rises in wait cycle 5 and stays 1 after the wait ends; rst_n low clears it.
